digit_format_seq: RTL and testbench

Sequential, parametrised successor to the combinational digit manager. It sits between the mode/data mux and the SevenSeg drivers. It accepts one display word per valid/ready handshake and scans the active digits one per cycle from the most significant downward to decide leading-zero blanking. It then commits data, decimal-point flags and blank flags together in one cycle, so the displays never show a partially updated frame.

---
 rtl/digit_format_seq.sv | 116 +++++++++++
 tb/tb_digit_format_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/digit_format_seq.sv
// digit_format_seq: scans display digits for leading-zero blanking and commits data/DP/Blank atomically; DIGIT_FORMAT_BLINK_EN adds overflow blinking
module digit_format_seq #(
  parameter int N_DIGITS = 6,
  parameter int N_ACTIVE = 4,
  parameter int N_MODES = 4,
  parameter int MODE_W = 2,
  parameter logic [4*N_MODES-1:0] DP_IDX = 16'h32FF,
  parameter logic [N_MODES-1:0] LZB_EN = 4'b1110,
  parameter int BLINK_HALF = 25_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*N_ACTIVE-1:0] data,
  input  logic [MODE_W-1:0]     mode,
  input  logic                  overflow,
  output logic                  out_valid,
  output logic [4*N_ACTIVE-1:0] digits_out,
  output logic [N_DIGITS-1:0]   DP,
  output logic [N_DIGITS-1:0]   Blank
);
  localparam int CW = $clog2(N_ACTIVE);
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
  state_t state;
  logic [4*N_ACTIVE-1:0] data_r;
  logic [MODE_W-1:0] mode_r;
  logic ovf_r, leading;
  logic [CW-1:0] cnt;
  logic [N_ACTIVE-1:0] mask;
  logic [N_DIGITS-1:0] blank_r, dp_n;
  logic [31:0] mi;
  logic [3:0] dp_field, floor_idx, nib;
  logic mode_ok, lzb, blank_now;
  always_comb begin
    mi = 32'(mode_r);
    mode_ok = mi < N_MODES;
    dp_field = mode_ok ? 4'(DP_IDX >> (4 * mi)) : 4'hF;
    lzb = mode_ok & |(LZB_EN & (N_MODES'(1) << mi));
    floor_idx = (dp_field == 4'hF) ? 4'd0 : dp_field;
    nib = 4'(data_r >> (4 * cnt));
    blank_now = leading & lzb & (nib == 4'd0) & (32'(cnt) > 32'(floor_idx));
    dp_n = (dp_field == 4'hF) ? '0 : N_DIGITS'(1) << dp_field;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      data_r <= '0;
      mode_r <= '0;
      ovf_r <= 1'b0;
      leading <= 1'b0;
      cnt <= '0;
      mask <= '0;
      digits_out <= '0;
      DP <= '0;
      blank_r <= '1;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          data_r <= data;
          mode_r <= mode;
          ovf_r <= overflow;
          cnt <= CW'(N_ACTIVE - 1);
          leading <= 1'b1;
          mask <= '0;
          in_ready <= 1'b0;
          state <= SCAN;
        end
        SCAN: begin
          if (blank_now) mask <= mask | (N_ACTIVE'(1) << cnt);
          else leading <= 1'b0;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= COMMIT;
        end
        default: begin
          digits_out <= data_r;
          DP <= dp_n;
          blank_r[N_ACTIVE-1:0] <= mask;
          out_valid <= 1'b1;
          in_ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
`ifdef DIGIT_FORMAT_BLINK_EN
  localparam int BW = $clog2(BLINK_HALF + 1);
  logic [BW-1:0] bcnt;
  logic dark, ovf_c;
  // phase restarts visible on every commit so a fresh frame is always seen first
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcnt <= '0;
      dark <= 1'b0;
      ovf_c <= 1'b0;
    end else if (state == COMMIT) begin
      bcnt <= '0;
      dark <= 1'b0;
      ovf_c <= ovf_r;
    end else if (bcnt == BW'(BLINK_HALF - 1)) begin
      bcnt <= '0;
      dark <= ~dark;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end
  assign Blank = (ovf_c & dark) ? '1 : blank_r;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_r;
  assign Blank = blank_r;
`endif
endmodule

// File: tb/tb_digit_format_seq.sv
// tb_digit_format_seq: directed-vector bench for digit_format_seq (blink checks follow DIGIT_FORMAT_BLINK_EN)
module tb_digit_format_seq;
  logic clk = 1'b0;
  logic reset_n, in_valid, overflow, in_ready, out_valid;
  logic [15:0] data, digits_out;
  logic [1:0] mode;
  logic [5:0] DP, Blank;
  int checks = 0;
  int errors = 0;

  digit_format_seq #(.BLINK_HALF(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .data(data), .mode(mode), .overflow(overflow), .out_valid(out_valid),
    .digits_out(digits_out), .DP(DP), .Blank(Blank)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  localparam logic [1:0]  TM [7] = '{2'd2, 2'd2, 2'd0, 2'd3, 2'd1, 2'd3, 2'd1};
  localparam logic [15:0] TD [7] = '{16'h0012, 16'h0000, 16'h0000, 16'h0305, 16'h0A00, 16'h0000, 16'h0000};
  localparam logic [5:0]  TB [7] = '{6'b111000, 6'b111000, 6'b110000, 6'b110000, 6'b111000, 6'b110000, 6'b111110};
  localparam logic [5:0]  TP [7] = '{6'b000100, 6'b000100, 6'b000000, 6'b001000, 6'b000000, 6'b001000, 6'b000000};

  task automatic xfer(input logic [1:0] m, input logic [15:0] d, input logic o,
                      output int lat, output logic busy_low);
    @(negedge clk);
    mode = m; data = d; overflow = o; in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    busy_low = !in_ready;
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = i; break; end
      if (in_ready) busy_low = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; in_valid = 1'b0; data = '0; mode = '0; overflow = 1'b0;
    #12;
    checks++; if (DP !== 6'b000000) begin errors++; $display("FAIL reset_dp got %b want %b", DP, 6'b000000); end
    checks++; if (Blank !== 6'b111111) begin errors++; $display("FAIL reset_blank got %b want %b", Blank, 6'b111111); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (digits_out !== 16'h0000) begin errors++; $display("FAIL reset_digits got %h want 0000", digits_out); end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic;
    int lat;
    logic busy;
    xfer(2'd1, 16'h0007, 1'b0, lat, busy);
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency got %0d want 4", lat); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_ready_low got %b want 1", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after got %b want 1", in_ready); end
    checks++; if (Blank !== 6'b111110) begin errors++; $display("FAIL basic_blank got %b want %b", Blank, 6'b111110); end
    checks++; if (DP !== 6'b000000) begin errors++; $display("FAIL basic_dp got %b want %b", DP, 6'b000000); end
    checks++; if (digits_out !== 16'h0007) begin errors++; $display("FAIL basic_digits got %h want 0007", digits_out); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse got %b want 0", out_valid); end
    checks++; if (digits_out !== 16'h0007) begin errors++; $display("FAIL basic_hold got %h want 0007", digits_out); end
  endtask

  task automatic test_blanking;
    int lat;
    logic busy;
    for (int t = 0; t < 7; t++) begin
      xfer(TM[t], TD[t], 1'b0, lat, busy);
      checks++; if (lat !== 4) begin errors++; $display("FAIL blank%0d_latency got %0d want 4", t, lat); end
      checks++; if (Blank !== TB[t]) begin errors++; $display("FAIL blank%0d_blank got %b want %b", t, Blank, TB[t]); end
      checks++; if (DP !== TP[t]) begin errors++; $display("FAIL blank%0d_dp got %b want %b", t, DP, TP[t]); end
      checks++; if (digits_out !== TD[t]) begin errors++; $display("FAIL blank%0d_digits got %h want %h", t, digits_out, TD[t]); end
    end
  endtask

  task automatic test_overflow;
    int lat;
    logic busy;
    logic [5:0] exp;
    xfer(2'd0, 16'h1234, 1'b0, lat, busy);
    for (int j = 0; j < 10; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
      checks++; if (Blank !== 6'b110000) begin errors++; $display("FAIL no_ovf_blank c%0d got %b want %b", j, Blank, 6'b110000); end
    end
    xfer(2'd0, 16'h1234, 1'b1, lat, busy);
    checks++; if (lat !== 4) begin errors++; $display("FAIL ovf_latency got %0d want 4", lat); end
    for (int j = 0; j < 12; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
`ifdef DIGIT_FORMAT_BLINK_EN
      exp = ((j / 4) % 2 == 1) ? 6'b111111 : 6'b110000;
`else
      exp = 6'b110000;
`endif
      checks++; if (Blank !== exp) begin errors++; $display("FAIL ovf_blank c%0d got %b want %b", j, Blank, exp); end
    end
  endtask

  task automatic test_back_to_back;
    int first, second;
    first = -1; second = -1;
    @(negedge clk);
    mode = 2'd1; data = 16'h0A00; overflow = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    mode = 2'd2; data = 16'h0012;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid && first < 0) begin
        first = i;
        checks++; if (digits_out !== 16'h0A00) begin errors++; $display("FAIL b2b_first_digits got %h want 0A00", digits_out); end
        checks++; if (Blank !== 6'b111000) begin errors++; $display("FAIL b2b_first_blank got %b want %b", Blank, 6'b111000); end
      end else if (first > 0 && i == first + 1) begin
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_taken got %b want 0", in_ready); end
      end else if (out_valid && first > 0) begin
        second = i;
        break;
      end
    end
    checks++; if (first !== 4) begin errors++; $display("FAIL b2b_first_latency got %0d want 4", first); end
    checks++; if (second !== 9) begin errors++; $display("FAIL b2b_second_latency got %0d want 9", second); end
    checks++; if (digits_out !== 16'h0012) begin errors++; $display("FAIL b2b_second_digits got %h want 0012", digits_out); end
    checks++; if (DP !== 6'b000100) begin errors++; $display("FAIL b2b_second_dp got %b want %b", DP, 6'b000100); end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_scan;
    int lat, seen;
    logic busy;
    @(negedge clk);
    mode = 2'd3; data = 16'h0305; overflow = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    checks++; if (DP !== 6'b000000) begin errors++; $display("FAIL midrst_dp got %b want %b", DP, 6'b000000); end
    checks++; if (Blank !== 6'b111111) begin errors++; $display("FAIL midrst_blank got %b want %b", Blank, 6'b111111); end
    checks++; if (digits_out !== 16'h0000) begin errors++; $display("FAIL midrst_digits got %h want 0000", digits_out); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", in_ready); end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (out_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_commit got %0d want 0", seen); end
    xfer(2'd3, 16'h0305, 1'b0, lat, busy);
    checks++; if (lat !== 4) begin errors++; $display("FAIL midrst_latency got %0d want 4", lat); end
    checks++; if (Blank !== 6'b110000) begin errors++; $display("FAIL midrst_blank2 got %b want %b", Blank, 6'b110000); end
    checks++; if (DP !== 6'b001000) begin errors++; $display("FAIL midrst_dp2 got %b want %b", DP, 6'b001000); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_blanking;
    test_overflow;
    test_back_to_back;
    test_reset_mid_scan;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
